painel_entrada: RTL and testbench
=================================

# painel_entrada

Front-panel input conditioner for the microwave controller. Samples a raw keypad code and a raw door switch, synchronises and debounces both, and assembles the controller's input bus. The bus is `t` (three BCD time digits), `r` (recipe code), `conf` (start pulse) and `porta` (door state). It sits between the physical panel and `main`, driving every input that `main` consumes.

## Interface
Parameters:
- `DEB_CICLOS`, default 4: consecutive stable synchronised samples required before a debounced level changes; legal range 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `tecla`  in  4  raw key code, valid while `tecla_valida` is high.
- `tecla_valida`  in  1  raw key-pressed level, asynchronous, bouncing.
- `sensor_porta`  in  1  raw door switch, 1 = open, asynchronous, bouncing.
- `t`  out  12  time entry, BCD: `t[11:8]` MSD, `t[3:0]` LSD.
- `r`  out  4  recipe code, BCD 0..9.
- `conf`  out  1  start request, one-cycle pulse.
- `porta`  out  1  debounced door state, 1 = open.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Synchronisation: `tecla_valida`, `sensor_porta` and `tecla` each pass through a 2-flop synchroniser.
- Debounce:
  - One counter per level input.
  - The counter increments while the synced value differs from the debounced value and clears when they match.
  - On reaching `DEB_CICLOS`, the debounced value flips and the counter clears.
- Key event: a single-cycle event fires on the 0→1 transition of debounced `tecla_valida`. The code is the synced `tecla` sampled that same cycle.
  - A held key produces exactly one event.
  - Release produces none.
- FSM, 2 states, reset to OCIOSO:
  - OCIOSO, key 0..9: `t <= {t[7:0], key}`. The MSD is discarded on the 4th and later digits (wrap, no saturation).
  - OCIOSO, key A: `t <= 0`, `r <= 0`.
  - OCIOSO, key B: `conf` pulses iff `porta == 0` and (`t != 0` or `r != 0`). `t` and `r` hold; otherwise no effect.
  - OCIOSO, key C: go to RECEITA.
  - OCIOSO, keys D..F: ignored.
  - RECEITA, key 0..9: `r <= key`, go to OCIOSO; `t` unchanged.
  - RECEITA, key A: `t <= 0`, `r <= 0`, go to OCIOSO.
  - RECEITA, any other key: go to OCIOSO, no data change.
- `porta` output equals the debounced door value. The door state does not block digit, recipe or clear entry, only `conf`.

## Timing
- Reset values: `t=0`, `r=0`, `conf=0`, `porta=0`, state OCIOSO.
  - All synchroniser flops, debounced values and counters are 0.
- Key latency: raw `tecla_valida` rises (with `tecla` stable) and stays high. `t`, `r` or `conf` respond at rising edge number `DEB_CICLOS + 3`, counted from the first edge that samples the high level.
- Door latency: `porta` changes at edge `DEB_CICLOS + 2` after a stable raw change.
- Glitch rejection: a raw pulse on `tecla_valida` shorter than `DEB_CICLOS` synced cycles produces no event.
- `conf` is high for exactly one cycle per accepted B event. It never asserts in two consecutive cycles.
- Door change and key B in the same cycle: the `conf` decision uses `porta` as registered before that edge.
- Reset mid-debounce or mid-RECEITA returns all state to reset values immediately. No event is generated on release of reset, even if keys are held.
  - A held key must be released and pressed again to register.

## Test plan
1. Reset with `tecla_valida=1` and `sensor_porta=1` held → `t=0x000`, `r=0`, `conf=0`, `porta=0`.
   - After release of reset: `porta=1` at edge 6 (`DEB_CICLOS=4`), no key event.
2. Keys 1, 2, 3, each held 10 cycles with 10-cycle gaps → `t=0x123`. Then key 4 → `t=0x234`. Key A → `t=0x000`, `r=0`.
3. Bounce: `tecla_valida` toggles high 3 cycles / low 1 cycle ×4, then stays high for 10 cycles with key 7 → exactly one event, `t=0x007`. A standalone 3-cycle pulse → no change.
4. Keys C then 5 → `r=5`, `t` unchanged, state OCIOSO. Keys C then B → `r` unchanged, no `conf`. Keys C then A → `t=0`, `r=0`.
5. `t=0x030`, door open, key B → `conf` stays 0.
   - Close door, wait 10 cycles, key B held 20 cycles → `conf=1` for exactly one cycle at edge 7 after the press.
   - With `t=0`, `r=0`, key B → no `conf`.
6. Assert `rst_n=0` two cycles into debouncing key 9 → `t` stays 0, and no event fires after reset releases while the key is still held.

Source files
------------

// File: rtl/painel_entrada.sv
// painel_entrada: front-panel input conditioner for the microwave controller.
// Synchronises the raw keypad and door switch, debounces the key-pressed level
// and the door level, turns each debounced key press into a single event and
// assembles the input bus consumed by main.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   tecla[3:0]    raw key code, valid while tecla_valida is high
//   tecla_valida  raw key-pressed level (asynchronous, bouncing)
//   sensor_porta  raw door switch, 1 = open (asynchronous, bouncing)
//   t[11:0]       time entry, three BCD digits, t[11:8] is the MSD
//   r[3:0]        recipe code, BCD 0..9
//   conf          start request, one-cycle pulse
//   porta         debounced door state, 1 = open
module painel_entrada #(
  parameter int unsigned DEB_CICLOS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  tecla,
  input  logic        tecla_valida,
  input  logic        sensor_porta,
  output logic [11:0] t,
  output logic [3:0]  r,
  output logic        conf,
  output logic        porta
);

  typedef enum logic {
    OCIOSO  = 1'b0,
    RECEITA = 1'b1
  } estado_t;

  typedef struct packed {
    logic       nivel;
    logic [7:0] cnt;
  } deb_t;

  localparam logic [7:0] CNT_LAST = 8'(DEB_CICLOS - 1);
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;

  // Counter runs while the synced level disagrees with the debounced level;
  // any agreement restarts it, so only an unbroken run of DEB_CICLOS flips it.
  function automatic deb_t deb_step(input deb_t cur, input logic sync);
    deb_t nxt;
    nxt = cur;
    if (sync == cur.nivel) begin
      nxt.cnt = '0;
    end else if (cur.cnt == CNT_LAST) begin
      nxt.nivel = ~cur.nivel;
      nxt.cnt   = '0;
    end else begin
      nxt.cnt = cur.cnt + 8'd1;
    end
    return nxt;
  endfunction

  logic       tv_s1_q, tv_s1_d, tv_s2_q, tv_s2_d;
  logic       sp_s1_q, sp_s1_d, sp_s2_q, sp_s2_d;
  logic [3:0] tecla_s1_q, tecla_s1_d, tecla_s2_q, tecla_s2_d;
  deb_t       tv_deb_q, tv_deb_d;
  deb_t       sp_deb_q, sp_deb_d;
  logic       tv_prev_q, tv_prev_d;
  logic [1:0] fill_q, fill_d;
  logic       arm_q, arm_d;
  estado_t    state_q, state_d;
  logic [11:0] t_q, t_d;
  logic [3:0]  r_q, r_d;
  logic        conf_q, conf_d;

  logic       key_evt;
  logic [3:0] key;

  // A key held through reset must not register: key events are only armed
  // once the synchroniser has been refilled after reset (fill_q == 2) and has
  // then shown the key released at least once.
  assign key_evt = arm_q & tv_deb_q.nivel & ~tv_prev_q;
  assign key     = tecla_s2_q;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    tv_s1_d    = tecla_valida;
    tv_s2_d    = tv_s1_q;
    sp_s1_d    = sensor_porta;
    sp_s2_d    = sp_s1_q;
    tecla_s1_d = tecla;
    tecla_s2_d = tecla_s1_q;
    tv_deb_d   = deb_step(tv_deb_q, tv_s2_q);
    sp_deb_d   = deb_step(sp_deb_q, sp_s2_q);
    tv_prev_d  = tv_deb_q.nivel;
    fill_d     = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    arm_d      = arm_q | ((fill_q == 2'd2) & ~tv_s2_q);
    state_d    = state_q;
    t_d        = t_q;
    r_d        = r_q;
    conf_d     = 1'b0;

    if (key_evt) begin
      unique case (state_q)
        OCIOSO: begin
          if (key <= 4'd9) begin
            t_d = {t_q[7:0], key};
          end else if (key == KEY_A) begin
            t_d = '0;
            r_d = '0;
          end else if (key == KEY_B) begin
            // Door state as registered before this edge gates the start.
            conf_d = ~sp_deb_q.nivel & ((t_q != '0) | (r_q != '0));
          end else if (key == KEY_C) begin
            state_d = RECEITA;
          end
        end
        RECEITA: begin
          state_d = OCIOSO;
          if (key <= 4'd9) begin
            r_d = key;
          end else if (key == KEY_A) begin
            t_d = '0;
            r_d = '0;
          end
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_s1_q    <= 1'b0;
      tv_s2_q    <= 1'b0;
      sp_s1_q    <= 1'b0;
      sp_s2_q    <= 1'b0;
      tecla_s1_q <= '0;
      tecla_s2_q <= '0;
      tv_deb_q   <= '0;
      sp_deb_q   <= '0;
      tv_prev_q  <= 1'b0;
      fill_q     <= '0;
      arm_q      <= 1'b0;
      state_q    <= OCIOSO;
      t_q        <= '0;
      r_q        <= '0;
      conf_q     <= 1'b0;
    end else begin
      tv_s1_q    <= tv_s1_d;
      tv_s2_q    <= tv_s2_d;
      sp_s1_q    <= sp_s1_d;
      sp_s2_q    <= sp_s2_d;
      tecla_s1_q <= tecla_s1_d;
      tecla_s2_q <= tecla_s2_d;
      tv_deb_q   <= tv_deb_d;
      sp_deb_q   <= sp_deb_d;
      tv_prev_q  <= tv_prev_d;
      fill_q     <= fill_d;
      arm_q      <= arm_d;
      state_q    <= state_d;
      t_q        <= t_d;
      r_q        <= r_d;
      conf_q     <= conf_d;
    end
  end

  assign t     = t_q;
  assign r     = r_q;
  assign conf  = conf_q;
  assign porta = sp_deb_q.nivel;

endmodule

// File: tb/tb_painel_entrada.sv
// Testbench for painel_entrada with DEB_CICLOS = 4. Inputs change and outputs
// are checked on the falling clock edge; conf pulses are counted 1 time unit
// after each rising edge.
module tb_painel_entrada;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tecla;
  logic        tecla_valida;
  logic        sensor_porta;
  logic [11:0] t;
  logic [3:0]  r;
  logic        conf;
  logic        porta;

  painel_entrada #(.DEB_CICLOS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .sensor_porta (sensor_porta),
    .t            (t),
    .r            (r),
    .conf         (conf),
    .porta        (porta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        door;
    logic [3:0]  key;
    logic [11:0] t;
    logic [3:0]  r;
    int          conf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int conf_cnt  = 0;
  int conf_cyc  = -1;
  int conf_dbl  = 0;
  logic conf_prev = 1'b0;
  int press_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (conf === 1'b1) begin
      conf_cnt = conf_cnt + 1;
      conf_cyc = cyc;
      if (conf_prev) conf_dbl = conf_dbl + 1;
    end
    conf_prev = (conf === 1'b1);
  end

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    @(negedge clk);
    tecla        = k;
    tecla_valida = 1'b1;
    press_cyc    = cyc;
    repeat (hold) @(negedge clk);
    tecla_valida = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic add(input logic door, input logic [3:0] k, input logic [11:0] et,
                     input logic [3:0] er, input int ec);
    vec_t v;
    v.door = door; v.key = k; v.t = et; v.r = er; v.conf = ec;
    vecs.push_back(v);
  endtask

  // Pushes the expected bus for a step, then pops it once the step completes.
  task automatic expect_now(input string name, input logic [11:0] et, input logic [3:0] er);
    vec_t v, e;
    v.door = sensor_porta; v.key = tecla; v.t = et; v.r = er; v.conf = 0;
    exp_q.push_back(v);
    e = exp_q.pop_front();
    check({name, "_t"}, int'(t), int'(e.t));
    check({name, "_r"}, int'(r), int'(e.r));
  endtask

  initial begin
    vec_t e;
    int c0;

    add(0, 4'h1, 12'h001, 4'd0, 0);
    add(0, 4'h2, 12'h012, 4'd0, 0);
    add(0, 4'h3, 12'h123, 4'd0, 0);
    add(0, 4'h4, 12'h234, 4'd0, 0);
    add(0, 4'hA, 12'h000, 4'd0, 0);
    add(0, 4'h9, 12'h009, 4'd0, 0);
    add(0, 4'hC, 12'h009, 4'd0, 0);
    add(0, 4'h5, 12'h009, 4'd5, 0);
    add(0, 4'h1, 12'h091, 4'd5, 0);
    add(0, 4'hC, 12'h091, 4'd5, 0);
    add(0, 4'hB, 12'h091, 4'd5, 0);
    add(0, 4'hD, 12'h091, 4'd5, 0);
    add(0, 4'hC, 12'h091, 4'd5, 0);
    add(0, 4'hA, 12'h000, 4'd0, 0);
    add(0, 4'h3, 12'h003, 4'd0, 0);
    add(0, 4'h0, 12'h030, 4'd0, 0);
    add(1, 4'hB, 12'h030, 4'd0, 0);
    add(1, 4'h2, 12'h302, 4'd0, 0);
    add(0, 4'hB, 12'h302, 4'd0, 1);
    add(0, 4'hA, 12'h000, 4'd0, 0);
    add(0, 4'hB, 12'h000, 4'd0, 0);
    add(0, 4'hF, 12'h000, 4'd0, 0);
    add(0, 4'hC, 12'h000, 4'd0, 0);
    add(0, 4'h7, 12'h000, 4'd7, 0);
    add(0, 4'hB, 12'h000, 4'd7, 1);
    add(0, 4'hA, 12'h000, 4'd0, 0);

    // Reset with key and door raw levels held high.
    rst_n        = 1'b0;
    tecla        = 4'h3;
    tecla_valida = 1'b1;
    sensor_porta = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_t", int'(t), 0);
    check("rst_r", int'(r), 0);
    check("rst_conf", int'(conf), 0);
    check("rst_porta", int'(porta), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) check("door_edge5", int'(porta), 0);
      if (k == 6) check("door_edge6", int'(porta), 1);
    end
    repeat (12) @(negedge clk);
    expect_now("held_through_reset", 12'h000, 4'd0);
    check("held_through_reset_conf", conf_cnt, 0);
    tecla_valida = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven key sequence.
    foreach (vecs[i]) begin
      if (sensor_porta != vecs[i].door) begin
        sensor_porta = vecs[i].door;
        repeat (10) @(negedge clk);
        check($sformatf("porta_v%0d", i), int'(porta), int'(vecs[i].door));
      end
      c0 = conf_cnt;
      exp_q.push_back(vecs[i]);
      press(vecs[i].key, 10, 10);
      e = exp_q.pop_front();
      check($sformatf("t_v%0d", i), int'(t), int'(e.t));
      check($sformatf("r_v%0d", i), int'(r), int'(e.r));
      check($sformatf("conf_v%0d", i), conf_cnt - c0, e.conf);
    end

    // conf timing with B held for 20 cycles.
    press(4'h5, 10, 10);
    expect_now("pre_conf", 12'h005, 4'd0);
    c0 = conf_cnt;
    press(4'hB, 20, 10);
    check("conf_count_long_hold", conf_cnt - c0, 1);
    check("conf_edge", conf_cyc - press_cyc, 7);

    // Bouncing press of key 7 followed by a stable high.
    press(4'hA, 10, 10);
    @(negedge clk);
    tecla = 4'h7;
    for (int b = 0; b < 4; b++) begin
      tecla_valida = 1'b1;
      repeat (3) @(negedge clk);
      tecla_valida = 1'b0;
      @(negedge clk);
    end
    tecla_valida = 1'b1;
    repeat (10) @(negedge clk);
    tecla_valida = 1'b0;
    repeat (10) @(negedge clk);
    expect_now("bounce", 12'h007, 4'd0);

    // Standalone 3-cycle glitch.
    press(4'h8, 3, 10);
    expect_now("glitch", 12'h007, 4'd0);

    // Reset two cycles into debouncing key 9, key held afterwards.
    @(negedge clk);
    tecla        = 4'h9;
    tecla_valida = 1'b1;
    repeat (4) @(negedge clk);
    c0    = conf_cnt;
    rst_n = 1'b0;
    #1;
    expect_now("mid_reset", 12'h000, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_now("after_reset_held", 12'h000, 4'd0);
    tecla_valida = 1'b0;
    repeat (10) @(negedge clk);
    expect_now("after_reset_released", 12'h000, 4'd0);
    check("after_reset_conf", conf_cnt - c0, 0);
    press(4'h6, 10, 10);
    expect_now("repress", 12'h006, 4'd0);

    check("conf_consecutive", conf_dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
